// File: rtl/posit_weight_serializer.sv
// Bit-serial posit weight transmitter: FIFO-buffered parallel words are shifted out
// MSB-first, one bit per cycle, with a precision-load strobe for the multiplier lanes.
module posit_weight_serializer #(
    parameter int MAX_PREC = 8,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_en,
    input  logic [3:0]          cfg_prec,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_PREC-1:0] in_data,
    output logic                out_w,
    output logic                out_valid,
    output logic                out_set,
    output logic [3:0]          out_precision,
    output logic                busy,
    output logic                err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [MAX_PREC-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [AW:0]         r_count;

    logic [3:0]          r_prec;
    logic [3:0]          r_bit_cnt;
    logic [MAX_PREC-1:0] r_shift;
    logic                r_configured;
    logic                r_set_pend;
    logic                r_out_set;
    logic                r_out_w;
    logic                r_out_valid;
    logic                r_err;
    logic [3:0]          r_out_precision;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_last;
    logic                w_cfg_ok;
    logic [3:0]          w_sh;
    logic [MAX_PREC-1:0] w_aligned;

    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign busy     = (r_state == S_SHIFT) | ~w_empty;
    assign in_ready = r_configured & ~w_full & ~r_out_set;
    assign w_push   = in_valid & in_ready;
    assign w_last   = (r_bit_cnt == (r_prec - 4'd1));
    assign w_cfg_ok = cfg_en & ~busy & (cfg_prec >= 4'd2) & (cfg_prec <= 4'(MAX_PREC));

    // Left-align the head word so its sign bit sits at the shift register MSB.
    assign w_sh      = 4'(MAX_PREC) - r_prec;
    assign w_aligned = r_mem[r_rptr] << w_sh;

    assign out_w         = r_out_w;
    assign out_valid     = r_out_valid;
    assign out_set       = r_out_set;
    assign out_precision = r_out_precision;
    assign err           = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The pending-set cycle also blocks a pop so out_valid stays low under out_set.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !r_out_set && !r_set_pend) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
        if (w_pop) begin
            r_shift <= w_aligned << 1;
        end else begin
            r_shift <= r_shift << 1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_bit_cnt       <= '0;
            r_out_w         <= 1'b0;
            r_out_valid     <= 1'b0;
            r_prec          <= '0;
            r_configured    <= 1'b0;
            r_set_pend      <= 1'b0;
            r_out_set       <= 1'b0;
            r_out_precision <= '0;
            r_err           <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase

            if (w_pop) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end

            if (w_pop) begin
                r_out_w <= w_aligned[MAX_PREC-1];
            end else if ((r_state == S_SHIFT) && !w_last) begin
                r_out_w <= r_shift[MAX_PREC-1];
            end else begin
                r_out_w <= 1'b0;
            end
            r_out_valid <= w_pop | ((r_state == S_SHIFT) & ~w_last);

            if (w_cfg_ok) begin
                r_prec       <= cfg_prec;
                r_configured <= 1'b1;
            end
            r_set_pend <= w_cfg_ok;
            r_out_set  <= r_set_pend;
            if (r_set_pend) begin
                r_out_precision <= r_prec;
            end
            r_err <= cfg_en & ~w_cfg_ok;
        end
    end

endmodule

// File: tb/tb_posit_weight_serializer.sv
// Scoreboarded bench for posit_weight_serializer: each accepted word queues its
// prec low bits MSB-first; a negedge monitor compares every valid serial bit.
module tb_posit_weight_serializer;

    localparam int MAX_PREC = 8;
    localparam int DEPTH    = 4;

    logic                clk;
    logic                rst;
    logic                cfg_en;
    logic [3:0]          cfg_prec;
    logic                in_valid;
    logic                in_ready;
    logic [MAX_PREC-1:0] in_data;
    logic                out_w;
    logic                out_valid;
    logic                out_set;
    logic [3:0]          out_precision;
    logic                busy;
    logic                err;

    posit_weight_serializer #(.MAX_PREC(MAX_PREC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_prec(cfg_prec),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_w(out_w), .out_valid(out_valid), .out_set(out_set),
        .out_precision(out_precision), .busy(busy), .err(err)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   m_prec = 1;
    int   m_outprec = 0;
    int   run = 0;
    logic sb_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: record accepted words, compare serial bits, check framing.
    always @(negedge clk) begin
        if (!rst) begin
            sb_q.delete();
            run = 0;
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    check("serial_bit", int'(out_w), int'(sb_q.pop_front()));
                end
                run++;
            end else if (run != 0) begin
                check("frame_len_mod_prec", run % m_prec, 0);
                run = 0;
            end
            if (out_set) check("valid_during_set", int'(out_valid), 0);
            if (in_valid && in_ready) begin
                for (int i = m_prec - 1; i >= 0; i--) sb_q.push_back(in_data[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [MAX_PREC-1:0] d);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            t++;
        end
        if (!ok) check("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || out_valid) && t < 400) begin
            tick();
            t++;
        end
        check("idle_timeout", int'(busy | out_valid), 0);
        tick();
    endtask

    task automatic cfg(input int p, input bit ok);
        cfg_en   = 1'b1;
        cfg_prec = 4'(p);
        tick();
        cfg_en = 1'b0;
        check("cfg_err", int'(err), ok ? 0 : 1);
        check("cfg_set_early", int'(out_set), 0);
        if (ok) m_prec = p;
        tick();
        check("cfg_set", int'(out_set), ok ? 1 : 0);
        if (ok) begin
            m_outprec = p;
            check("cfg_valid_low", int'(out_valid), 0);
        end
        check("cfg_precision", int'(out_precision), m_outprec);
        tick();
        check("cfg_err_pulse", int'(err), 0);
        check("cfg_set_pulse", int'(out_set), 0);
    endtask

    initial begin
        int  gaps;
        bit  acc;
        rst      = 1'b0;
        cfg_en   = 1'b0;
        cfg_prec = '0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) tick();
        check("rst_out_w", int'(out_w), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_set", int'(out_set), 0);
        check("rst_out_precision", int'(out_precision), 0);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        tick();

        // Unconfigured block refuses words.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (4) begin
            tick();
            check("unconf_in_ready", int'(in_ready), 0);
            check("unconf_out_valid", int'(out_valid), 0);
        end
        in_valid = 1'b0;
        tick();

        // Single word, with first-bit and last-bit latency.
        cfg(5, 1'b1);
        push(8'h16);
        check("single_lat0", int'(out_valid), 0);
        tick();
        check("single_first_valid", int'(out_valid), 1);
        check("single_first_bit", int'(out_w), 1);
        repeat (4) tick();
        check("single_last_valid", int'(out_valid), 1);
        check("single_last_bit", int'(out_w), 0);
        tick();
        check("single_done_valid", int'(out_valid), 0);
        check("single_done_busy", int'(busy), 0);
        wait_idle();

        // Back-to-back words stream without a gap.
        cfg(4, 1'b1);
        push(8'h07);
        push(8'h08);
        gaps = 0;
        for (int c = 0; c < 8; c++) begin
            if (!out_valid) gaps++;
            if (c != 7) tick();
        end
        check("b2b_gaps", gaps, 0);
        tick();
        check("b2b_end", int'(out_valid), 0);
        wait_idle();

        // FIFO fill with in_valid held from IDLE.
        cfg(8, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        gaps     = 0;
        for (int e = 1; e <= 50; e++) begin
            @(negedge clk);
            acc = in_valid & in_ready;
            tick();
            if (e <= 11) check($sformatf("full_accept_e%0d", e), int'(acc), (e <= 5 || e == 11) ? 1 : 0);
            if (acc) in_data = 8'($urandom);
            if (e == 11) in_valid = 1'b0;
            if (e >= 2 && e <= 49 && !out_valid) gaps++;
            if (e == 50) check("full_stream_end", int'(out_valid), 0);
        end
        check("full_stream_gaps", gaps, 0);
        wait_idle();

        // Rejected configurations.
        cfg(9, 1'b0);
        cfg(1, 1'b0);
        cfg(0, 1'b0);
        push(8'($urandom));
        push(8'($urandom));
        tick();
        check("busy_while_stream", int'(busy), 1);
        cfg(3, 1'b0);
        wait_idle();

        // Randomized rounds.
        for (int r = 0; r < 6; r++) begin
            cfg($urandom_range(2, MAX_PREC), 1'b1);
            for (int j = 0; j < int'($urandom_range(3, 8)); j++) begin
                if ($urandom_range(0, 2) == 0) tick();
                push(8'($urandom));
            end
            wait_idle();
        end

        // Reset in the middle of a word.
        cfg(6, 1'b1);
        push(8'($urandom));
        tick();
        tick();
        check("mid_valid_before_rst", int'(out_valid), 1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_async_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        tick();
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin
            tick();
            check("post_rst_in_ready", int'(in_ready), 0);
            check("post_rst_out_valid", int'(out_valid), 0);
        end
        check("post_rst_precision", int'(out_precision), 0);
        in_valid  = 1'b0;
        m_outprec = 0;
        cfg(3, 1'b1);
        push(8'($urandom));
        wait_idle();

        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
